// File: rtl/rs_decode_stream_unpack.sv
// rs_decode_stream_unpack: receive-side unpacker for the RS encoded line stream.
// Data lines pass straight through to the data output. The parity lines that follow
// are split into one PARITY_W word per block and emitted from a holding register.
// Optional framing checks and the DRAIN state are enabled by RS_UNPACK_FRAME_CHECK_EN.
module rs_decode_stream_unpack #(
  parameter int unsigned NUM_REQ_BLOCKS_W = 8,
  parameter int unsigned DATA_W           = 256,
  parameter int unsigned PARITY_W         = 64,
  parameter int unsigned NUM_LINES        = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        src_unpack_req_val,
  input  logic [NUM_REQ_BLOCKS_W-1:0] src_unpack_req_num_blocks,
  output logic                        unpack_src_req_rdy,
  input  logic                        src_unpack_data_val,
  input  logic [DATA_W-1:0]           src_unpack_data,
  input  logic                        src_unpack_data_last,
  output logic                        unpack_src_data_rdy,
  output logic                        unpack_dst_data_val,
  output logic [DATA_W-1:0]           unpack_dst_data,
  output logic                        unpack_dst_data_last,
  input  logic                        dst_unpack_data_rdy,
  output logic                        unpack_dst_parity_val,
  output logic [PARITY_W-1:0]         unpack_dst_parity,
  output logic [NUM_REQ_BLOCKS_W-1:0] unpack_dst_parity_block,
  input  logic                        dst_unpack_parity_rdy,
  output logic                        unpack_err
);

  localparam int unsigned R      = DATA_W / PARITY_W;
  localparam int unsigned SLOT_W = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [NUM_REQ_BLOCKS_W-1:0] BLK_ONE = NUM_REQ_BLOCKS_W'(1);
  localparam logic [NUM_REQ_BLOCKS_W-1:0] R_BLK   = NUM_REQ_BLOCKS_W'(R);
  localparam logic [LINE_W-1:0]           LINE_MAX = LINE_W'(NUM_LINES - 1);
  localparam logic [SLOT_W-1:0]           SLOT_MAX = SLOT_W'(R - 1);

`ifdef RS_UNPACK_FRAME_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, DRAIN} state_t;

  state_t                      state, state_nxt;
  logic [NUM_REQ_BLOCKS_W-1:0] num_blocks;
  logic [LINE_W-1:0]           line_cnt;
  logic [NUM_REQ_BLOCKS_W-1:0] block_cnt;
  logic [NUM_REQ_BLOCKS_W-1:0] line_block;  // block index of slot 0 of the next parity line
  logic [DATA_W-1:0]           par_reg;
  logic                        par_valid;
  logic [NUM_REQ_BLOCKS_W-1:0] par_block;
  logic [SLOT_W-1:0]           slot;
  logic                        got_final;
  logic                        drain_pend;
  logic                        err_q;

  logic                        req_hs, data_hs, line_hs, par_hs, abort, err_set;
  logic                        last_slot, final_line, line_end, last_data;
  logic [NUM_REQ_BLOCKS_W-1:0] rem_blocks;

  assign par_hs     = par_valid && dst_unpack_parity_rdy;
  // Slots beyond block N-1 exist only on the final line, so block N-1 also ends that line.
  assign last_slot  = (slot == SLOT_MAX) || (par_block == num_blocks - BLK_ONE);
  assign rem_blocks = num_blocks - line_block;
  assign final_line = (32'(rem_blocks) <= R);
  assign line_end   = (line_cnt == LINE_MAX);
  assign last_data  = line_end && (block_cnt == num_blocks - BLK_ONE);

  assign unpack_dst_data         = src_unpack_data;
  assign unpack_dst_parity_val   = par_valid;
  assign unpack_dst_parity       = par_reg[DATA_W-1 -: PARITY_W];
  assign unpack_dst_parity_block = par_block;
  assign unpack_err              = err_q;

  // Next-state, handshake and ready/valid generation.
  always_comb begin
    state_nxt            = state;
    unpack_src_req_rdy   = 1'b0;
    unpack_src_data_rdy  = 1'b0;
    unpack_dst_data_val  = 1'b0;
    unpack_dst_data_last = 1'b0;
    req_hs               = 1'b0;
    data_hs              = 1'b0;
    line_hs              = 1'b0;
    abort                = 1'b0;
    err_set              = 1'b0;
    case (state)
      IDLE: begin
        unpack_src_req_rdy = 1'b1;
        req_hs             = src_unpack_req_val;
        if (src_unpack_req_val && (src_unpack_req_num_blocks != '0)) state_nxt = DATA;
      end
      DATA: begin
        if (CHECK && src_unpack_data_last) begin
          // An early last line is swallowed rather than forwarded.
          unpack_src_data_rdy = 1'b1;
          if (src_unpack_data_val) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          unpack_dst_data_val  = src_unpack_data_val;
          unpack_src_data_rdy  = dst_unpack_data_rdy;
          unpack_dst_data_last = src_unpack_data_val && last_data;
          data_hs              = src_unpack_data_val && dst_unpack_data_rdy;
          if (data_hs && last_data) state_nxt = PARITY;
        end
      end
      PARITY: begin
        unpack_src_data_rdy = !got_final && (!par_valid || (par_hs && last_slot));
        line_hs             = src_unpack_data_val && unpack_src_data_rdy;
        if (par_hs && (par_block == num_blocks - BLK_ONE))
          state_nxt = drain_pend ? DRAIN : IDLE;
        if (line_hs && CHECK) begin
          if (src_unpack_data_last && !final_line) begin
            abort     = 1'b1;
            err_set   = 1'b1;
            state_nxt = IDLE;
          end else if (!src_unpack_data_last && final_line) begin
            err_set = 1'b1;
          end
        end
      end
      DRAIN: begin
        unpack_src_data_rdy = 1'b1;
        if (src_unpack_data_val && src_unpack_data_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and the parity holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      num_blocks <= '0;
      line_cnt   <= '0;
      block_cnt  <= '0;
      line_block <= '0;
      par_reg    <= '0;
      par_valid  <= 1'b0;
      par_block  <= '0;
      slot       <= '0;
      got_final  <= 1'b0;
      drain_pend <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      err_q <= err_set;
      if (req_hs) begin
        num_blocks <= src_unpack_req_num_blocks;
        line_cnt   <= '0;
        block_cnt  <= '0;
        line_block <= '0;
        par_valid  <= 1'b0;
        par_block  <= '0;
        slot       <= '0;
        got_final  <= 1'b0;
        drain_pend <= 1'b0;
      end
      if (data_hs) begin
        if (line_end) begin
          line_cnt  <= '0;
          block_cnt <= block_cnt + BLK_ONE;
        end else begin
          line_cnt <= line_cnt + LINE_W'(1);
        end
      end
      if (par_hs) begin
        par_block <= par_block + BLK_ONE;
        slot      <= slot + SLOT_W'(1);
        par_reg   <= par_reg << PARITY_W;
        if (last_slot) par_valid <= 1'b0;
      end
      // A load in the same cycle as the last slot handshake overrides the updates above.
      if (line_hs) begin
        if (abort) begin
          par_valid <= 1'b0;
        end else begin
          par_reg    <= src_unpack_data;
          par_valid  <= 1'b1;
          par_block  <= line_block;
          slot       <= '0;
          line_block <= line_block + R_BLK;
          if (final_line) begin
            got_final  <= 1'b1;
            drain_pend <= CHECK && !src_unpack_data_last;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_decode_stream_unpack.sv
// Directed bench for rs_decode_stream_unpack with R=4 (128-bit lines, 32-bit parity),
// three lines per block. Expectations adapt to RS_UNPACK_FRAME_CHECK_EN.
module tb_rs_decode_stream_unpack;

  localparam int unsigned BW = 8;
  localparam int unsigned DW = 128;
  localparam int unsigned PW = 32;
  localparam int unsigned NL = 3;

`ifdef RS_UNPACK_FRAME_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_val;
  logic [BW-1:0] req_num;
  logic          req_rdy;
  logic          src_val;
  logic [DW-1:0] src_data;
  logic          src_last;
  logic          src_rdy;
  logic          dst_val;
  logic [DW-1:0] dst_data;
  logic          dst_last;
  logic          dst_rdy;
  logic          par_val;
  logic [PW-1:0] par_word;
  logic [BW-1:0] par_blk;
  logic          par_rdy;
  logic          err;

  int checks = 0;
  int errors = 0;

  `define CHK(tag, obs, exp) \
    begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
        errors++; \
        $error("FAIL %s observed=%0h required=%0h", tag, (obs), (exp)); \
      end \
    end

  always #5 clk = ~clk;

  rs_decode_stream_unpack #(
    .NUM_REQ_BLOCKS_W(BW),
    .DATA_W(DW),
    .PARITY_W(PW),
    .NUM_LINES(NL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .src_unpack_req_val(req_val),
    .src_unpack_req_num_blocks(req_num),
    .unpack_src_req_rdy(req_rdy),
    .src_unpack_data_val(src_val),
    .src_unpack_data(src_data),
    .src_unpack_data_last(src_last),
    .unpack_src_data_rdy(src_rdy),
    .unpack_dst_data_val(dst_val),
    .unpack_dst_data(dst_data),
    .unpack_dst_data_last(dst_last),
    .dst_unpack_data_rdy(dst_rdy),
    .unpack_dst_parity_val(par_val),
    .unpack_dst_parity(par_word),
    .unpack_dst_parity_block(par_blk),
    .dst_unpack_parity_rdy(par_rdy),
    .unpack_err(err)
  );

  function automatic logic [DW-1:0] dline(input int b, input int l);
    logic [31:0] w;
    w = 32'hD000_0000 + 32'(b * 256 + l);
    return {w, w ^ 32'h5A5A_5A5A, w + 32'd7, ~w};
  endfunction

  // Parity line k carries words A0000000+k*4+s in slot s, slot 0 in the MS position.
  function automatic logic [DW-1:0] pline(input int k);
    logic [31:0] base;
    base = 32'hA000_0000 + 32'(k * 4);
    return {base, base + 32'd1, base + 32'd2, base + 32'd3};
  endfunction

  // mode 0: clean stream; mode 1: last=1 on data line 1; mode 2: final parity last=0 plus two trailing lines.
  task automatic run_stream(input int n, input bit stall, input int mode);
    logic [DW-1:0] lines [$];
    bit            lasts [$];
    logic [DW-1:0] exp_d [$];
    bit            exp_dl [$];
    logic [PW-1:0] exp_p [$];
    logic [BW-1:0] exp_b [$];
    int p, idx, cyc, n_consume, exp_err, err_cnt, noisy, stuck;
    bit hold;
    logic [DW-1:0] w;
    for (int b = 0; b < n; b++)
      for (int l = 0; l < int'(NL); l++) begin
        lines.push_back(dline(b, l));
        lasts.push_back(1'b0);
        exp_d.push_back(dline(b, l));
        exp_dl.push_back(b == n - 1 && l == int'(NL) - 1);
      end
    p = (n + 3) / 4;
    for (int k = 0; k < p; k++) begin
      lines.push_back(pline(k));
      lasts.push_back(k == p - 1 && mode != 2);
    end
    for (int j = 0; j < n; j++) begin
      exp_p.push_back(32'hA000_0000 + 32'(j));
      exp_b.push_back(BW'(j));
    end
    n_consume = lines.size();
    exp_err = 0;
    if (mode == 1) begin
      lasts[1] = 1'b1;
      if (CHK_EN) begin
        while (lines.size() > 2) begin void'(lines.pop_back()); void'(lasts.pop_back()); end
        while (exp_d.size() > 1) begin void'(exp_d.pop_back()); void'(exp_dl.pop_back()); end
        exp_p.delete();
        exp_b.delete();
        n_consume = 2;
        exp_err = 1;
      end
    end
    if (mode == 2) begin
      for (int t = 0; t < 2; t++) begin
        w = {4{32'hEEEE_0000 + 32'(t)}};
        lines.push_back(w);
        lasts.push_back(t == 1);
      end
      n_consume = CHK_EN ? lines.size() : lines.size() - 2;
      exp_err = CHK_EN ? 1 : 0;
    end

    @(negedge clk);
    req_val = 1'b1;
    req_num = BW'(n);
    #1;
    `CHK("req_rdy_idle", req_rdy, 1'b1)
    @(negedge clk);
    req_val = 1'b0;

    idx = 0; cyc = 0; hold = 1'b0; err_cnt = 0;
    while (!(idx >= n_consume && exp_d.size() == 0 && exp_p.size() == 0) && cyc < 400) begin
      if (idx < n_consume) begin
        if (!hold) src_val = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        src_data = lines[idx];
        src_last = lasts[idx];
      end else begin
        src_val = 1'b0;
      end
      dst_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      par_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (err) err_cnt++;
      if (dst_val && dst_rdy) begin
        if (exp_d.size() == 0) begin
          `CHK("data_extra", dst_val, 1'b0)
        end else begin
          `CHK("data_line", dst_data, exp_d.pop_front())
          `CHK("data_last", dst_last, exp_dl.pop_front())
        end
      end
      if (par_val && par_rdy) begin
        if (exp_p.size() == 0) begin
          `CHK("parity_extra", par_val, 1'b0)
        end else begin
          `CHK("parity_word", par_word, exp_p.pop_front())
          `CHK("parity_block", par_blk, exp_b.pop_front())
        end
      end
      if (src_val && src_rdy) begin
        idx++;
        hold = 1'b0;
      end else begin
        hold = src_val;
      end
      cyc++;
      @(negedge clk);
    end
    `CHK("cycle_budget", cyc < 400, 1'b1)
    `CHK("lines_consumed", idx, n_consume)

    noisy = 0; stuck = 0;
    for (int t = 0; t < 3; t++) begin
      if (idx < int'(lines.size())) begin
        src_val = 1'b1;
        src_data = lines[idx];
        src_last = lasts[idx];
      end else begin
        src_val = 1'b0;
      end
      dst_rdy = 1'b1;
      par_rdy = 1'b1;
      #1;
      if (t == 0) `CHK("req_rdy_after", req_rdy, 1'b1)
      if (err) err_cnt++;
      if (dst_val || par_val) noisy++;
      if (src_val && src_rdy) stuck++;
      @(negedge clk);
    end
    src_val = 1'b0;
    src_last = 1'b0;
    `CHK("tail_quiet", noisy, 0)
    `CHK("tail_no_accept", stuck, 0)
    `CHK("err_pulses", err_cnt, exp_err)
  endtask

  initial begin
    int idx;
    rst = 1'b0;
    req_val = 1'b0;
    req_num = '0;
    src_val = 1'b0;
    src_data = '0;
    src_last = 1'b0;
    dst_rdy = 1'b1;
    par_rdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    `CHK("rst_req_rdy", req_rdy, 1'b1)
    `CHK("rst_src_rdy", src_rdy, 1'b0)
    `CHK("rst_dst_val", dst_val, 1'b0)
    `CHK("rst_dst_last", dst_last, 1'b0)
    `CHK("rst_par_val", par_val, 1'b0)
    `CHK("rst_err", err, 1'b0)
    @(negedge clk);
    rst = 1'b1;

    // N=3: one parity line, slot 3 dropped.
    run_stream(3, 1'b0, 0);
    // N=5: two parity lines, block 4 from the MS slot of line 1.
    run_stream(5, 1'b0, 0);
    // N=2 under random stalls on source and both sinks.
    run_stream(2, 1'b1, 0);
    run_stream(2, 1'b1, 0);

    // N=0 consumes nothing and stays idle.
    @(negedge clk);
    req_val = 1'b1;
    req_num = '0;
    @(negedge clk);
    req_val = 1'b0;
    src_val = 1'b1;
    src_data = dline(0, 0);
    #1;
    `CHK("n0_req_rdy", req_rdy, 1'b1)
    `CHK("n0_src_rdy", src_rdy, 1'b0)
    `CHK("n0_dst_val", dst_val, 1'b0)
    src_val = 1'b0;

    // Framing cases.
    run_stream(1, 1'b0, 1);
    run_stream(1, 1'b0, 2);

    // Reset while the parity register holds an un-emitted word.
    @(negedge clk);
    req_val = 1'b1;
    req_num = BW'(1);
    @(negedge clk);
    req_val = 1'b0;
    par_rdy = 1'b0;
    dst_rdy = 1'b1;
    idx = 0;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      src_val = 1'b1;
      src_data = (idx < 3) ? dline(0, idx) : pline(0);
      src_last = (idx == 3);
      #1;
      if (src_rdy) idx++;
      @(negedge clk);
    end
    src_val = 1'b1;
    src_data = dline(0, 0);
    src_last = 1'b0;
    #1;
    `CHK("pre_rst_par_val", par_val, 1'b1)
    `CHK("pre_rst_par_word", par_word, 32'hA000_0000)
    #2 rst = 1'b0;
    #1;
    `CHK("async_rst_par_val", par_val, 1'b0)
    `CHK("async_rst_req_rdy", req_rdy, 1'b1)
    `CHK("async_rst_src_rdy", src_rdy, 1'b0)
    `CHK("async_rst_dst_val", dst_val, 1'b0)
    `CHK("async_rst_err", err, 1'b0)
    src_val = 1'b0;
    par_rdy = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    run_stream(1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
